// File: rtl/data_memory_multi_pe_if.sv
// data_memory_multi_pe_if: per-PE request/grant and read-return bundle for the banked data memory
interface data_memory_multi_pe_if #(
  parameter int NUM_PE = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [NUM_PE-1:0]            req;
  logic [NUM_PE-1:0]            we;
  logic [NUM_PE*ADDR_W-1:0]     addr;
  logic [NUM_PE*DATA_W-1:0]     wdata;
  logic [NUM_PE*(DATA_W/8)-1:0] be;
  logic [NUM_PE-1:0]            gnt;
  logic [NUM_PE-1:0]            rvalid;
  logic [NUM_PE*DATA_W-1:0]     rdata;
  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_memory_multi_pe.sv
// data_memory_multi_pe: word-interleaved banked memory shared by NUM_PE ports,
// per-bank round-robin arbitration, byte-enabled writes, 1-cycle registered reads
module data_memory_multi_pe #(
  parameter int NUM_PE    = 2,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 32
) (
  input logic clk,
  input logic rst,
  data_memory_multi_pe_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LB   = $clog2(NUM_BANKS);
  localparam int BW   = LB > 0 ? LB : 1;
  localparam int ROWS = DEPTH / NUM_BANKS;
  localparam int RW   = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int PW   = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
  localparam int BEW  = DATA_W / 8;
  logic [DATA_W-1:0] mem [NUM_BANKS][ROWS];
  logic [BW-1:0]     bank_of [NUM_PE];
  logic [RW-1:0]     row_of  [NUM_PE];
  logic [DATA_W-1:0] wd      [NUM_PE];
  logic [BEW-1:0]    bep     [NUM_PE];
  logic [PW-1:0]     ptr     [NUM_BANKS];
  logic [PW-1:0]     bsel    [NUM_BANKS];
  logic [NUM_BANKS-1:0] bv;
  logic [NUM_PE-1:0] gnt;
  logic [NUM_PE-1:0] rvalid;
  logic [DATA_W-1:0] rdata [NUM_PE];
  logic [PW-1:0]     idx;
  logic              unused_addr;
  assign unused_addr = ^bus.addr;
  for (genvar p = 0; p < NUM_PE; p++) begin : g_port
    logic [AW-1:0] wa;
    assign wa         = bus.addr[p*ADDR_W +: AW];
    assign bank_of[p] = LB > 0 ? BW'(wa) : '0;
    assign row_of[p]  = RW'(wa >> LB);
    assign wd[p]      = bus.wdata[p*DATA_W +: DATA_W];
    assign bep[p]     = bus.be[p*BEW +: BEW];
    assign bus.rdata[p*DATA_W +: DATA_W] = rdata[p];
  end
  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid;
  // Scan ports starting at each bank's pointer; the first requester wins that bank.
  always_comb begin
    gnt  = '0;
    bv   = '0;
    idx  = '0;
    bsel = '{default: '0};
    for (int k = 0; k < NUM_BANKS; k++)
      for (int i = 0; i < NUM_PE; i++) begin
        idx = PW'((32'(ptr[k]) + 32'(i)) % NUM_PE);
        if (rst && !bv[k] && bus.req[idx] && bank_of[idx] == BW'(k)) begin
          bv[k]    = 1'b1;
          bsel[k]  = idx;
          gnt[idx] = 1'b1;
        end
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '{default: '0};
    else
      for (int k = 0; k < NUM_BANKS; k++)
        if (bv[k]) ptr[k] <= bsel[k] == PW'(NUM_PE - 1) ? '0 : bsel[k] + 1'b1;
  always_ff @(posedge clk)
    for (int k = 0; k < NUM_BANKS; k++)
      for (int b = 0; b < BEW; b++)
        if (bv[k] && bus.we[bsel[k]] && bep[bsel[k]][b])
          mem[k][row_of[bsel[k]]][8*b +: 8] <= wd[bsel[k]][8*b +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rvalid <= '0;
      rdata  <= '{default: '0};
    end else
      for (int p = 0; p < NUM_PE; p++) begin
        rvalid[p] <= gnt[p] && !bus.we[p];
        if (gnt[p] && !bus.we[p]) rdata[p] <= mem[bank_of[p]][row_of[p]];
      end
endmodule
